// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake, occupancy, watermark and error
// signals of the parametrised synchronous FIFO. The master modport belongs to
// the producer/consumer side, the slave modport to the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  walmost_full;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rempty;
  logic                  ralmost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO of 2**ADDR_WIDTH words with live
// occupancy count, almost-full/almost-empty watermarks and sticky
// overflow/underflow flags. All flags are registered from the next count, so
// winc/rinc never reach a flag combinationally.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (rdata shows the head word, rvalid = !rempty); the default is a registered
// read with a one-cycle rvalid pulse.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int AFULL_TH   = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int                  DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] L_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] L_AFULL  = (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] L_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_wfull;
  logic                  r_rempty;
  logic                  r_walmost_full;
  logic                  r_ralmost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Accept decisions use only the registered flags of the current cycle.
  assign w_wr_acc = bus.winc && !r_wfull;
  assign w_rd_acc = bus.rinc && !r_rempty;

  // Next occupancy: simultaneous accepted read and write cancel out.
  always_comb begin
    // NOTE: default first so every path assigns w_count_nxt and no latch is inferred.
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage write; reset only rewinds the pointers, so old words are simply lost.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset branch; clearing it would forbid RAM inference and nothing reads unwritten words.
    if (!rst && w_wr_acc) begin
      r_mem[r_wptr] <= bus.wdata;
    end
  end

  // Pointers, count, registered flags and sticky error bits.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_count         <= '0;
      r_wfull         <= 1'b0;
      r_rempty        <= 1'b1;
      r_walmost_full  <= (L_AFULL == '0);
      r_ralmost_empty <= 1'b1;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count         <= w_count_nxt;
      r_wfull         <= (w_count_nxt == L_DEPTH);
      r_rempty        <= (w_count_nxt == '0);
      r_walmost_full  <= (w_count_nxt >= L_AFULL);
      r_ralmost_empty <= (w_count_nxt <= L_AEMPTY);
      // A new error in the same cycle as clr_err keeps the flag set.
      if (bus.winc && r_wfull)       r_overflow  <= 1'b1;
      else if (bus.clr_err)          r_overflow  <= 1'b0;
      if (bus.rinc && r_rempty)      r_underflow <= 1'b1;
      else if (bus.clr_err)          r_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; its value is meaningless while empty.
  assign bus.rdata  = r_mem[r_rptr];
  assign bus.rvalid = !r_rempty;
`else
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  // Registered read: popped word appears after the read edge and then holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= r_mem[r_rptr];
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
`endif

  assign bus.count         = r_count;
  assign bus.wfull         = r_wfull;
  assign bus.rempty        = r_rempty;
  assign bus.walmost_full  = r_walmost_full;
  assign bus.ralmost_empty = r_ralmost_empty;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;

endmodule
